tile_cfg_loader: RTL and testbench
==================================

Name: tile_cfg_loader

Overview:
- Writer side of the tile configuration interface: takes a byte-serial bitstream and assembles 77-bit configuration frames (field order CLB, BL, TR, S).
- Drives the per-tile one-cycle `wr_en` / `bits` write that each Tile samples.
- Sits between the off-chip config port and the tile array; one loader serves N_TILES tiles.

Parameters:
- FRAME_W, 77, configuration frame width per tile.
- N_TILES, 4, number of tiles addressed.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- cfg_valid  in  1  input byte valid
- cfg_data  in  8  input byte
- cfg_ready  out  1  loader can accept a byte
- wr_en  out  N_TILES  one-hot tile write strobe
- bits  out  FRAME_W  frame to tiles, shared by all tiles
- frame_ok  out  1  one-cycle pulse on successful commit
- frame_err  out  1  one-cycle pulse on a dropped frame
- loaded  out  N_TILES  sticky bitmap of tiles written since reset

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset: all outputs are 0, state is HUNT, byte counter is 0, checksum accumulator is 0. cfg_ready becomes 1 on the first cycle after reset deasserts.
- A byte transfers when cfg_valid && cfg_ready at a posedge. cfg_ready is 1 in every state except COMMIT.
- Frame format: SYNC_BYTE, tile index byte, 10 payload bytes, checksum byte.
  - Payload is LSB-first: byte k fills bits[8k+7:8k].
  - The top 3 bits of byte 9 (positions 77..79) are discarded.
  - Checksum is the XOR of the index byte and all 10 payload bytes.
- State machine:
  - HUNT: a byte equal to SYNC_BYTE goes to ADDR. Any other byte is discarded silently (no frame_err).
  - ADDR: latch the index and go to DATA. An index >= N_TILES is still consumed through CSUM, then flagged as an error.
  - DATA: accept 10 bytes with a counter 0..9. After byte 9, go to CSUM.
  - CSUM: on a match with a valid index, go to COMMIT. Otherwise pulse frame_err for one cycle, go to HUNT, and leave wr_en and bits untouched.
  - COMMIT: held for exactly one cycle.
    - wr_en[idx]=1 and bits=assembled frame.
    - frame_ok=1, and loaded[idx] is set.
    - Next state is HUNT.
- Outside COMMIT, wr_en=0 and bits=0. Tiles see bits only alongside wr_en.
- Latency: the commit cycle is the cycle after the checksum byte handshake.
- Idle gaps (cfg_valid=0) are allowed anywhere; state holds during them.
- A byte equal to SYNC_BYTE mid-frame is treated as data, never as a resync.
- Re-writing an already loaded tile is permitted; its loaded bit stays 1.
- Reset mid-frame: the partial frame is discarded, no wr_en fires, and loaded clears.
- Every output is registered; no combinational path from cfg_data to wr_en or bits.

Optional Feature:
- Macro TILE_CFG_CSUM_EN.
- Defined: the frame carries a checksum byte, and the CSUM state and checksum check are active as above.
- Undefined: there is no checksum byte. DATA goes straight to COMMIT after byte 9.
  - An index >= N_TILES pulses frame_err in the cycle after byte 9, and the loader returns to HUNT.
  - The checksum accumulator is not synthesized.

Decomposition:
- Package tile_cfg_pkg holds:
  - FRAME_W (77) and PAYLOAD_BYTES (10)
  - SYNC_BYTE
  - the state enum {HUNT, ADDR, DATA, CSUM, COMMIT}
  - field offset constants CLB, BL, TR, S for benches
- Sub-module cfg_frame_assembler: a byte-lane shift/insert register with payload counter and XOR accumulator, and clear/load controls. It is instantiated once by tile_cfg_loader, which holds the FSM and output registers.

Test Plan:
- Basic write: A5, 02, 10 bytes packing a known 77-bit pattern, correct XOR. Expect one cycle with wr_en=4'b0100, bits=that pattern, frame_ok=1, loaded=4'b0100; bits=0 in the cycles before and after.
- Bad checksum: same frame with checksum XOR'd with 01. Expect frame_err pulse, wr_en stays 0, loaded unchanged.
- Bad index: index 07 with N_TILES=4 and valid checksum. Expect frame_err pulse and no wr_en.
- Hunting and gaps: bytes 00, 3C, then a valid frame for tile 0 with random cfg_valid=0 gaps and an A5 byte inside the payload. Expect exactly one wr_en=4'b0001 and no frame_err.
- Reset mid-frame: rst_n=0 for one cycle after payload byte 5, then a full valid frame for tile 1. Expect a single commit, to tile 1 only, and loaded=4'b0010.
- Backpressure: cfg_valid held at 1 continuously across two back-to-back frames. Expect cfg_ready=0 only in each COMMIT cycle, and both tiles written in order.

Source files
------------

// File: rtl/tile_cfg_pkg.sv
// Shared constants and state encoding for the tile configuration loader.
// Optional checksum stage is enabled with TILE_CFG_CSUM_EN.
package tile_cfg_pkg;

  localparam int FRAME_W       = 77;
  localparam int PAYLOAD_BYTES = 10;
  localparam int BUF_W         = 8 * PAYLOAD_BYTES;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef logic [2:0] state_t;

  localparam state_t HUNT   = 3'd0;
  localparam state_t ADDR   = 3'd1;
  localparam state_t DATA   = 3'd2;
  localparam state_t CSUM   = 3'd3;
  localparam state_t COMMIT = 3'd4;

  // Field LSB offsets inside a frame, packed CLB first.
  localparam int CLB_LSB = 0;
  localparam int CLB_W   = 48;
  localparam int BL_LSB  = 48;
  localparam int BL_W    = 16;
  localparam int TR_LSB  = 64;
  localparam int TR_W    = 8;
  localparam int S_LSB   = 72;
  localparam int S_W     = 5;

endpackage

// File: rtl/cfg_frame_assembler.sv
// Byte-lane insert register, payload counter and XOR accumulator.
// XOR accumulator exists only when TILE_CFG_CSUM_EN is defined.
module cfg_frame_assembler
  import tile_cfg_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               load,
`ifdef TILE_CFG_CSUM_EN
  input  logic               acc_en,
  output logic [7:0]         csum,
`endif
  input  logic [7:0]         data_in,
  output logic               last,
  output logic [FRAME_W-1:0] frame_nxt
);

  logic [BUF_W-1:0] buf_q, buf_d;
  logic [3:0]       cnt_q, cnt_d;

  assign last = (cnt_q == 4'(PAYLOAD_BYTES - 1));

  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      for (int k = 0; k < PAYLOAD_BYTES; k++) begin
        if (cnt_q == k[3:0]) buf_d[8*k +: 8] = data_in;
      end
      cnt_d = last ? '0 : cnt_q + 4'd1;
    end
  end

  // Lookahead so a commit can register the frame with its final byte.
  assign frame_nxt = buf_d[FRAME_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef TILE_CFG_CSUM_EN
  logic [7:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr)         acc_d = '0;
    else if (acc_en) acc_d = acc_q ^ data_in;
  end

  assign csum = acc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end
`endif

endmodule

// File: rtl/tile_cfg_loader.sv
// Byte-serial config loader: sync, index, payload and commit to one tile.
// Checksum byte and check are present only with TILE_CFG_CSUM_EN.
module tile_cfg_loader
  import tile_cfg_pkg::*;
#(
  parameter int N_TILES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  input  logic [7:0]         cfg_data,
  output logic               cfg_ready,
  output logic [N_TILES-1:0] wr_en,
  output logic [FRAME_W-1:0] bits,
  output logic               frame_ok,
  output logic               frame_err,
  output logic [N_TILES-1:0] loaded
);

  state_t               state_q, state_d;
  logic [7:0]           idx_q, idx_d;
  logic                 ready_q, ready_d;
  logic [N_TILES-1:0]   wr_en_q, wr_en_d;
  logic [FRAME_W-1:0]   bits_q, bits_d;
  logic                 ok_q, ok_d;
  logic                 err_q, err_d;
  logic [N_TILES-1:0]   loaded_q, loaded_d;

  logic                 xfer;
  logic                 idx_ok;
  logic                 commit;
  logic                 clr;
  logic                 load;
  logic                 last;
  logic [FRAME_W-1:0]   frame_nxt;
`ifdef TILE_CFG_CSUM_EN
  logic                 acc_en;
  logic [7:0]           csum;
`endif

  cfg_frame_assembler u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .load      (load),
`ifdef TILE_CFG_CSUM_EN
    .acc_en    (acc_en),
    .csum      (csum),
`endif
    .data_in   (cfg_data),
    .last      (last),
    .frame_nxt (frame_nxt)
  );

  assign xfer   = cfg_valid && ready_q;
  assign idx_ok = (idx_q < 8'(N_TILES));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wr_en_d  = '0;
    bits_d   = '0;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    loaded_d = loaded_q;
    clr      = 1'b0;
    load     = 1'b0;
    commit   = 1'b0;
`ifdef TILE_CFG_CSUM_EN
    acc_en   = 1'b0;
`endif
    unique case (state_q)
      HUNT: begin
        clr = 1'b1;
        if (xfer && cfg_data == SYNC_BYTE) state_d = ADDR;
      end
      ADDR: begin
        if (xfer) begin
          idx_d   = cfg_data;
          state_d = DATA;
`ifdef TILE_CFG_CSUM_EN
          acc_en  = 1'b1;
`endif
        end
      end
      DATA: begin
        if (xfer) begin
          load = 1'b1;
`ifdef TILE_CFG_CSUM_EN
          acc_en = 1'b1;
          if (last) state_d = CSUM;
`else
          if (last) begin
            if (idx_ok) begin
              commit = 1'b1;
            end else begin
              err_d   = 1'b1;
              state_d = HUNT;
            end
          end
`endif
        end
      end
`ifdef TILE_CFG_CSUM_EN
      CSUM: begin
        if (xfer) begin
          if (idx_ok && cfg_data == csum) begin
            commit = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = HUNT;
          end
        end
      end
`endif
      COMMIT: state_d = HUNT;
      default: state_d = HUNT;
    endcase

    // Outputs are registered on entry so they are valid in the COMMIT cycle.
    if (commit) begin
      state_d = COMMIT;
      ok_d    = 1'b1;
      bits_d  = frame_nxt;
      for (int i = 0; i < N_TILES; i++) begin
        wr_en_d[i] = (idx_q == 8'(i));
      end
      loaded_d = loaded_q | wr_en_d;
    end

    ready_d = (state_d != COMMIT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      idx_q    <= '0;
      ready_q  <= 1'b0;
      wr_en_q  <= '0;
      bits_q   <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      loaded_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ready_q  <= ready_d;
      wr_en_q  <= wr_en_d;
      bits_q   <= bits_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      loaded_q <= loaded_d;
    end
  end

  assign cfg_ready = ready_q;
  assign wr_en     = wr_en_q;
  assign bits      = bits_q;
  assign frame_ok  = ok_q;
  assign frame_err = err_q;
  assign loaded    = loaded_q;

endmodule

// File: tb/tb_tile_cfg_loader.sv
// Scoreboard bench for tile_cfg_loader with a frame-level reference model.
// Builds with or without TILE_CFG_CSUM_EN.
module tb_tile_cfg_loader;
  import tile_cfg_pkg::*;

  localparam int NT = 4;

  typedef struct {
    logic [NT-1:0]      wr_en;
    logic [FRAME_W-1:0] bits;
    logic               ok;
    logic               err;
    logic [NT-1:0]      loaded;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cfg_valid = 1'b0;
  logic [7:0]         cfg_data = '0;
  logic               cfg_ready;
  logic [NT-1:0]      wr_en;
  logic [FRAME_W-1:0] bits;
  logic               frame_ok;
  logic               frame_err;
  logic [NT-1:0]      loaded;

  int     n_vec = 0;
  int     n_bad = 0;
  exp_t   expq[$];
  logic [NT-1:0] loaded_m = '0;
  logic   rst_q;

  tile_cfg_loader #(.N_TILES(NT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .wr_en     (wr_en),
    .bits      (bits),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .loaded    (loaded)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rst_q <= rst_n;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: every visible event must match the next expected record.
  always @(negedge clk) begin
    if (rst_q === 1'b0) begin
      chk("reset_outs", {cfg_ready, wr_en, bits, frame_ok, frame_err, loaded},
          '0);
    end else if (rst_q === 1'b1) begin
      chk("ready", 128'(cfg_ready), 128'(wr_en == '0));
      if (wr_en == '0) chk("bits_idle", 128'(bits), '0);
      if (wr_en != '0 || frame_ok || frame_err) begin
        if (expq.size() == 0) begin
          chk("unexpected_evt", {wr_en, frame_ok, frame_err}, '0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("wr_en", 128'(wr_en), 128'(e.wr_en));
          chk("bits", 128'(bits), 128'(e.bits));
          chk("ok_err", {frame_ok, frame_err}, {e.ok, e.err});
          chk("loaded_evt", 128'(loaded), 128'(e.loaded));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps && $urandom_range(0, 1) == 1) begin
      cfg_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    cfg_valid = 1'b1;
    cfg_data  = b;
    for (int t = 0; t < 8 && !cfg_ready; t++) @(negedge clk);
    if (!cfg_ready) chk("ready_timeout", 0, 1);
    @(negedge clk);
  endtask

  // Reference: a frame commits iff index < NT and the checksum matches.
  task automatic send_frame(input logic [7:0] idx, input logic [79:0] pl,
                            input bit corrupt, input bit gaps,
                            input int stop_after);
    logic [7:0] cs;
    exp_t       e;
    bit         good;
    cs = idx;
    for (int k = 0; k < PAYLOAD_BYTES; k++) cs ^= pl[8*k +: 8];
`ifdef TILE_CFG_CSUM_EN
    good = (idx < NT) && !corrupt;
`else
    good = (idx < NT);
`endif
    if (stop_after < 0) begin
      e.wr_en = '0; e.bits = '0; e.ok = 1'b0; e.err = 1'b1;
      if (good) begin
        loaded_m[idx[1:0]] = 1'b1;
        e.wr_en = '0;
        e.wr_en[idx[1:0]] = 1'b1;
        e.bits = pl[FRAME_W-1:0];
        e.ok = 1'b1;
        e.err = 1'b0;
      end
      e.loaded = loaded_m;
      expq.push_back(e);
    end
    send_byte(SYNC_BYTE, gaps);
    send_byte(idx, gaps);
    for (int k = 0; k < PAYLOAD_BYTES; k++) begin
      if (stop_after >= 0 && k > stop_after) return;
      send_byte(pl[8*k +: 8], gaps);
    end
`ifdef TILE_CFG_CSUM_EN
    send_byte(cs ^ {7'd0, corrupt}, gaps);
`endif
  endtask

  task automatic idle(input int n);
    cfg_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [79:0] pat;
    logic [95:0] r;
    pat = 80'hE3A5_0123_4567_89AB_CDEF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    send_frame(8'h02, pat, 1'b0, 1'b0, -1);
    idle(3);
    chk("loaded_basic", 128'(loaded), 128'(4'b0100));
`ifdef TILE_CFG_CSUM_EN
    send_frame(8'h02, ~pat, 1'b1, 1'b0, -1);
    idle(3);
`endif
    send_frame(8'h07, pat, 1'b0, 1'b0, -1);
    idle(3);

    send_byte(8'h00, 1'b0);
    send_byte(8'h3C, 1'b0);
    pat[39:32] = SYNC_BYTE;
    send_frame(8'h00, pat, 1'b0, 1'b1, -1);
    idle(3);
    chk("loaded_hunt", 128'(loaded), 128'(4'b0101));

    send_frame(8'h01, pat, 1'b0, 1'b0, 5);
    cfg_valid = 1'b0;
    rst_n = 1'b0;
    loaded_m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(8'h01, ~pat, 1'b0, 1'b0, -1);
    idle(3);
    chk("loaded_rst", 128'(loaded), 128'(4'b0010));

    send_frame(8'h03, pat, 1'b0, 1'b0, -1);
    send_frame(8'h00, ~pat, 1'b0, 1'b0, -1);
    idle(3);

    for (int n = 0; n < 24; n++) begin
      r = {$urandom, $urandom, $urandom};
      send_frame(8'($urandom_range(0, 5)), r[79:0],
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1), -1);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(4);
    chk("queue_drained", 128'(expq.size()), '0);
    chk("loaded_final", 128'(loaded), 128'(loaded_m));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
